// File: rtl/iddr_gearbox.sv
// iddr_gearbox: behavioural input-DDR capture and word assembler.
//
// Each bit time, d is sampled on the rising and on the falling clock edge.
// Samples are paired according to the bit phase and packed into words of
// RATIO pairs. The oldest pair sits in the LSBs.
//
// Ports:
//   clk        clock; also sets the DDR bit time
//   rst_n      synchronous reset, active low
//   d          DDR data input, WIDTH bits per edge
//   ce         pair qualifier, sampled with the rising-edge sample
//   slip       one-cycle pulse; toggles the bit phase
//   word_slip  one-cycle pulse; drops the next valid pair (word boundary shift)
//   out_data   assembled word, 2*WIDTH*RATIO bits, holds between strobes
//   out_valid  one-cycle word strobe
//   out_phase  bit phase that was used for the emitted word
module iddr_gearbox #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned RATIO    = 2,
    parameter int unsigned PIPELINE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           d,
    input  logic                       ce,
    input  logic                       slip,
    input  logic                       word_slip,
    output logic [2*WIDTH*RATIO-1:0]   out_data,
    output logic                       out_valid,
    output logic                       out_phase
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned WW = PW * RATIO;
    localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CntLast = CW'(RATIO - 1);

    // Capture flops carry no reset; pair_v gates everything downstream.
    logic [WIDTH-1:0] r_q, f_q, f_prev_q;

    always_ff @(posedge clk) begin
        r_q      <= d;
        f_prev_q <= f_q;
    end

    always_ff @(negedge clk) begin
        f_q <= d;
    end

    logic          c_q, c_d;
    logic          phase_q, phase_d;
    logic [PW-1:0] pair_q, pair_d;
    logic          pair_v_q, pair_v_d;
    logic          pair_phase_q, pair_phase_d;
    logic          ws_q, ws_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] sr_q, sr_d;
    logic [WW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          oph_q, oph_d;

    always_comb begin
        c_d          = ce;
        phase_d      = phase_q ^ slip;
        // phase 1 pairs the rising sample with the falling sample before it
        pair_d       = phase_q ? {r_q, f_prev_q} : {f_q, r_q};
        pair_v_d     = c_q;
        pair_phase_d = phase_q;

        ws_d    = ws_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        oph_d   = oph_q;

        if (pair_v_q && ws_q) begin
            // armed word slip swallows this pair; a pulse now is ignored
            ws_d = 1'b0;
        end else begin
            if (word_slip) begin
                ws_d = 1'b1;
            end
            if (pair_v_q) begin
                sr_d              = sr_q >> PW;
                sr_d[WW-1 -: PW]  = pair_q;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    data_d  = sr_d;
                    valid_d = 1'b1;
                    oph_d   = pair_phase_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q          <= 1'b0;
            phase_q      <= 1'b0;
            pair_q       <= '0;
            pair_v_q     <= 1'b0;
            pair_phase_q <= 1'b0;
            ws_q         <= 1'b0;
            cnt_q        <= '0;
            sr_q         <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            oph_q        <= 1'b0;
        end else begin
            c_q          <= c_d;
            phase_q      <= phase_d;
            pair_q       <= pair_d;
            pair_v_q     <= pair_v_d;
            pair_phase_q <= pair_phase_d;
            ws_q         <= ws_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            oph_q        <= oph_d;
        end
    end

    if (PIPELINE > 0) begin : g_pipe
        logic [WW-1:0] pdata_q  [PIPELINE];
        logic [WW-1:0] pdata_d  [PIPELINE];
        logic          pvalid_q [PIPELINE];
        logic          pvalid_d [PIPELINE];
        logic          pphase_q [PIPELINE];
        logic          pphase_d [PIPELINE];

        always_comb begin
            pdata_d[0]  = data_q;
            pvalid_d[0] = valid_q;
            pphase_d[0] = oph_q;
            for (int unsigned i = 1; i < PIPELINE; i++) begin
                pdata_d[i]  = pdata_q[i-1];
                pvalid_d[i] = pvalid_q[i-1];
                pphase_d[i] = pphase_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            for (int unsigned i = 0; i < PIPELINE; i++) begin
                if (!rst_n) begin
                    pdata_q[i]  <= '0;
                    pvalid_q[i] <= 1'b0;
                    pphase_q[i] <= 1'b0;
                end else begin
                    pdata_q[i]  <= pdata_d[i];
                    pvalid_q[i] <= pvalid_d[i];
                    pphase_q[i] <= pphase_d[i];
                end
            end
        end

        assign out_data  = pdata_q[PIPELINE-1];
        assign out_valid = pvalid_q[PIPELINE-1];
        assign out_phase = pphase_q[PIPELINE-1];
    end else begin : g_nopipe
        assign out_data  = data_q;
        assign out_valid = valid_q;
        assign out_phase = oph_q;
    end

endmodule

// File: tb/tb_iddr_gearbox.sv
// Scoreboard bench for iddr_gearbox. Three instances share d and rst_n:
//   u_a WIDTH=4 RATIO=2 PIPELINE=0 (slip/word_slip driven)
//   u_b WIDTH=4 RATIO=4 PIPELINE=0
//   u_c WIDTH=4 RATIO=1 PIPELINE=3
// Stimulus pushes hand-computed words with their expected strobe cycle; a
// negedge monitor pops and compares whenever an instance strobes.
module tb_iddr_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] d;
    logic       ce_a, ce_b, ce_c, slip_a, ws_a;
    logic [15:0] od_a;
    logic [31:0] od_b;
    logic [7:0]  od_c;
    logic        ov_a, op_a, ov_b, op_b, ov_c, op_c;

    iddr_gearbox #(.WIDTH(4), .RATIO(2), .PIPELINE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .d(d), .ce(ce_a), .slip(slip_a), .word_slip(ws_a),
        .out_data(od_a), .out_valid(ov_a), .out_phase(op_a)
    );

    iddr_gearbox #(.WIDTH(4), .RATIO(4), .PIPELINE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .d(d), .ce(ce_b), .slip(1'b0), .word_slip(1'b0),
        .out_data(od_b), .out_valid(ov_b), .out_phase(op_b)
    );

    iddr_gearbox #(.WIDTH(4), .RATIO(1), .PIPELINE(3)) u_c (
        .clk(clk), .rst_n(rst_n), .d(d), .ce(ce_c), .slip(1'b0), .word_slip(1'b0),
        .out_data(od_c), .out_valid(ov_c), .out_phase(op_c)
    );

    typedef struct {
        logic [31:0] data;
        logic        phase;
        int          cyc;
    } exp_t;

    exp_t q[3][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    int   k;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, need %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] dat, input logic ph);
        exp_t e;
        if (v) begin
            total++;
            if (q[p].size() == 0) begin
                bad++;
                $display("FAIL strobe%0d: unexpected out_valid at cycle %0d, data=%h, need none",
                         p, cyc_n, dat);
            end else begin
                e = q[p].pop_front();
                if (dat !== e.data || ph !== e.phase || cyc_n != e.cyc) begin
                    bad++;
                    $display("FAIL word%0d: got data=%h phase=%0d cycle=%0d, need data=%h phase=%0d cycle=%0d",
                             p, dat, ph, cyc_n, e.data, e.phase, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov_a, 32'(od_a), op_a);
        mon(1, ov_b, od_b, op_b);
        mon(2, ov_c, 32'(od_c), op_c);
    end

    // One bit time: r sampled at the posedge, f at the following negedge.
    // ce bits are {c, b, a}; returns the posedge index of the rising sample.
    task automatic cyc(input logic [3:0] r, input logic [3:0] f, input logic [2:0] c,
                       input logic s, input logic w, input logic rst, output int kk);
        d = r; ce_a = c[0]; ce_b = c[1]; ce_c = c[2]; slip_a = s; ws_a = w; rst_n = rst;
        @(posedge clk);
        #1;
        kk = cyc_n;
        d = f; ce_a = 1'b0; ce_b = 1'b0; ce_c = 1'b0; slip_a = 1'b0; ws_a = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int kk;
        for (int i = 0; i < n; i++) cyc(4'h0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, kk);
    endtask

    task automatic push(input int p, input logic [31:0] dat, input logic ph, input int at);
        q[p].push_back('{data: dat, phase: ph, cyc: at});
    endtask

    initial begin
        // reset
        for (int i = 0; i < 3; i++) cyc(4'h0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b0, k);
        chk("rst_a_data", 32'(od_a), 32'h0);
        chk("rst_a_valid", 32'(ov_a), 32'h0);
        chk("rst_a_phase", 32'(op_a), 32'h0);
        chk("rst_b_data", od_b, 32'h0);
        chk("rst_b_valid", 32'(ov_b), 32'h0);
        chk("rst_b_phase", 32'(op_b), 32'h0);
        chk("rst_c_data", 32'(od_c), 32'h0);
        chk("rst_c_valid", 32'(ov_c), 32'h0);
        chk("rst_c_phase", 32'(op_c), 32'h0);

        // basic assembly, phase 0
        cyc(4'h1, 4'h2, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h3, 4'h4, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'h4321, 1'b0, k + 2);
        cyc(4'h5, 4'h6, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h7, 4'h8, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'h8765, 1'b0, k + 2);
        idle(4);
        chk("hold_a_data", 32'(od_a), 32'h8765);

        // bit slip to phase 1, pair of 1 skipped via ce
        cyc(4'h0, 4'h0, 3'b000, 1'b1, 1'b0, 1'b1, k);
        cyc(4'h1, 4'h2, 3'b000, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h3, 4'h4, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h5, 4'h6, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'h5432, 1'b1, k + 2);
        cyc(4'h7, 4'h8, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h9, 4'h0, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'h9876, 1'b1, k + 2);
        cyc(4'h0, 4'h0, 3'b000, 1'b1, 1'b0, 1'b1, k);
        idle(3);
        chk("hold_a_phase", 32'(op_a), 32'h1);
        cyc(4'h1, 4'h2, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h3, 4'h4, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'h4321, 1'b0, k + 2);
        idle(4);

        // word slip drops the 5,6 pair
        cyc(4'h1, 4'h2, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h3, 4'h4, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'h4321, 1'b0, k + 2);
        cyc(4'h5, 4'h6, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h7, 4'h8, 3'b001, 1'b0, 1'b1, 1'b1, k);
        cyc(4'h9, 4'hA, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'hA987, 1'b0, k + 2);
        cyc(4'hB, 4'hC, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'hD, 4'hE, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'hEDCB, 1'b0, k + 2);
        idle(4);

        // ce gaps, RATIO=4
        cyc(4'h1, 4'h2, 3'b010, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h3, 4'h4, 3'b010, 1'b0, 1'b0, 1'b1, k);
        for (int i = 0; i < 3; i++) cyc(4'hF, 4'hF, 3'b000, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h5, 4'h6, 3'b010, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h7, 4'h8, 3'b010, 1'b0, 1'b0, 1'b1, k); push(1, 32'h87654321, 1'b0, k + 2);
        idle(4);

        // RATIO=1 with three output stages
        cyc(4'h1, 4'h2, 3'b100, 1'b0, 1'b0, 1'b1, k); push(2, 32'h21, 1'b0, k + 5);
        cyc(4'h3, 4'h4, 3'b100, 1'b0, 1'b0, 1'b1, k); push(2, 32'h43, 1'b0, k + 5);
        cyc(4'h5, 4'h6, 3'b100, 1'b0, 1'b0, 1'b1, k); push(2, 32'h65, 1'b0, k + 5);
        cyc(4'h0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h7, 4'h8, 3'b100, 1'b0, 1'b0, 1'b1, k); push(2, 32'h87, 1'b0, k + 5);
        idle(7);

        // reset after one of two pairs
        cyc(4'h1, 4'h2, 3'b001, 1'b0, 1'b0, 1'b1, k);
        idle(2);
        cyc(4'h0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b0, k);
        chk("midrst_a_data", 32'(od_a), 32'h0);
        chk("midrst_a_valid", 32'(ov_a), 32'h0);
        chk("midrst_a_phase", 32'(op_a), 32'h0);
        chk("midrst_b_data", od_b, 32'h0);
        chk("midrst_c_data", 32'(od_c), 32'h0);
        cyc(4'h5, 4'h6, 3'b001, 1'b0, 1'b0, 1'b1, k);
        cyc(4'h7, 4'h8, 3'b001, 1'b0, 1'b0, 1'b1, k); push(0, 32'h8765, 1'b0, k + 2);
        idle(4);

        chk("pending_a", 32'(q[0].size()), 32'h0);
        chk("pending_b", 32'(q[1].size()), 32'h0);
        chk("pending_c", 32'(q[2].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
